// File: rtl/hazard_control_unit.sv
// Purpose: pipeline hazard control (load-use stall, branch flush, multi-cycle mul/div hold with timeout).
// Latency: all pipeline controls are combinational in the current cycle; counters and flags update on the next edge.
// Backpressure: stalls PC/IF/ID on load-use and freezes the front end for the whole mul/div wait.
module hazard_control_unit #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_uses_rs1,
    input  logic             if_id_uses_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_is_muldiv,
    input  logic             ex_branch_taken,
    input  logic             md_done,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             md_start,
    output logic             md_abort,
    output logic             md_busy,
    output logic             md_timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // Wide enough to hold MD_TIMEOUT-1; a 1-bit counter covers the degenerate MD_TIMEOUT=1 case.
    localparam int WAIT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              timeout_hit;

    // Load-use: EX holds a load whose non-x0 destination is read by the instruction in ID.
    always_comb begin
        load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                   (((id_ex_rd == if_id_rs1) && if_id_uses_rs1) ||
                    ((id_ex_rd == if_id_rs2) && if_id_uses_rs2));
    end

    // Last permitted wait cycle; only meaningful while in MD_WAIT.
    always_comb begin
        timeout_hit = (wait_cnt == WAIT_LAST);
    end

    // Next-state and pipeline control outputs; priority is branch > mul/div > load-use in RUN,
    // and done > timeout in MD_WAIT. Start/abort pulses are suppressed while reset is held.
    always_comb begin
        next_state    = state;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        md_start      = 1'b0;
        md_abort      = 1'b0;
        md_busy       = 1'b0;
        case (state)
            RUN: begin
                if (ex_branch_taken) begin
                    // Squash the wrong-path instructions in IF/ID and ID/EX; PC takes the target.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (id_ex_is_muldiv) begin
                    // Freeze the front end and keep the unfinished result out of EX/MEM.
                    md_start      = !rst;
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                    next_state    = MD_WAIT;
                end else if (load_use) begin
                    // Hold PC and IF/ID one cycle; ID/EX captures a bubble.
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            MD_WAIT: begin
                md_busy = 1'b1;
                if (md_done) begin
                    // Result is valid: release everything so it enters EX/MEM.
                    next_state = RUN;
                end else if (timeout_hit) begin
                    // Give up: release the pipeline but keep the bubble so the bogus result is dropped.
                    ex_mem_bubble = 1'b1;
                    md_abort      = !rst;
                    next_state    = RUN;
                end else begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                end
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    // State register and wait counter; the counter sits at zero in RUN so it starts clean on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == MD_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_timeout_err <= 1'b0;
        end else if (md_abort) begin
            md_timeout_err <= 1'b1;
        end
    end

    // Saturating performance counters: stalled-PC cycles and IF/ID flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (if_id_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Purpose: self-checking bench for hazard_control_unit with a per-cycle expected-output scoreboard.
// Latency: outputs sampled 1ns after the input-driving negedge; counters checked after the following edge.
// Backpressure: none; the bench drives one stimulus vector per cycle.
module tb_hazard_control_unit;

    localparam int MD_TIMEOUT = 8;
    localparam int CNT_W      = 4;

    // Output vector order: {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
    //                       ex_mem_bubble, md_start, md_abort, md_busy}
    localparam logic [8:0] P_NORMAL  = 9'b111_000_000;
    localparam logic [8:0] P_LOADUSE = 9'b001_010_000;
    localparam logic [8:0] P_BRANCH  = 9'b111_110_000;
    localparam logic [8:0] P_MDSTART = 9'b000_001_100;
    localparam logic [8:0] P_MDWAIT  = 9'b000_001_001;
    localparam logic [8:0] P_MDDONE  = 9'b111_000_001;
    localparam logic [8:0] P_MDABORT = 9'b111_001_011;

    logic             clk;
    logic             rst;
    logic [4:0]       if_id_rs1;
    logic [4:0]       if_id_rs2;
    logic             if_id_uses_rs1;
    logic             if_id_uses_rs2;
    logic [4:0]       id_ex_rd;
    logic             id_ex_mem_read;
    logic             id_ex_is_muldiv;
    logic             ex_branch_taken;
    logic             md_done;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_bubble;
    logic             md_start;
    logic             md_abort;
    logic             md_busy;
    logic             md_timeout_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic [8:0] obs_vec;
    logic [8:0] exp_q[$];
    int         tests_run;
    int         tests_failed;

    assign obs_vec = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
                      ex_mem_bubble, md_start, md_abort, md_busy};

    hazard_control_unit #(
        .MD_TIMEOUT(MD_TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_id_rs1      (if_id_rs1),
        .if_id_rs2      (if_id_rs2),
        .if_id_uses_rs1 (if_id_uses_rs1),
        .if_id_uses_rs2 (if_id_uses_rs2),
        .id_ex_rd       (id_ex_rd),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_is_muldiv(id_ex_is_muldiv),
        .ex_branch_taken(ex_branch_taken),
        .md_done        (md_done),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .id_ex_write    (id_ex_write),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_bubble  (ex_mem_bubble),
        .md_start       (md_start),
        .md_abort       (md_abort),
        .md_busy        (md_busy),
        .md_timeout_err (md_timeout_err),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic mr,
                          input logic md, input logic br, input logic dn);
        if_id_rs1       = rs1;
        if_id_rs2       = rs2;
        if_id_uses_rs1  = u1;
        if_id_uses_rs2  = u2;
        id_ex_rd        = rd;
        id_ex_mem_read  = mr;
        id_ex_is_muldiv = md;
        ex_branch_taken = br;
        md_done         = dn;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Push the expected output pattern for the inputs just driven, then pop and compare.
    task automatic step(input string tag, input logic [8:0] exp);
        logic [8:0] e;
        exp_q.push_back(exp);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {23'd0, obs_vec}, {23'd0, e});
        end
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        idle();
        @(negedge clk);
        tick();

        // Reset state
        step("reset_outputs", P_NORMAL);
        rst = 1'b0;
        check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        check("reset_err", 32'(md_timeout_err), 32'd0);
        step("idle_run", P_NORMAL);

        // Load-use on rs1
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("loaduse_rs1", P_LOADUSE);
        idle();
        step("after_loaduse", P_NORMAL);
        check("loaduse_stall_cnt", 32'(stall_cnt), 32'd1);

        // Load to x0, unused source, and a real rs2 hazard
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("load_x0", P_NORMAL);
        set_in(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step("unused_rs2", P_NORMAL);
        set_in(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step("loaduse_rs2", P_LOADUSE);
        set_in(5'd3, 5'd7, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        step("done_ignored_in_run", P_NORMAL);
        check("rs2_stall_cnt", 32'(stall_cnt), 32'd2);

        // Branch overrides load-use
        do_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        step("branch_over_loaduse", P_BRANCH);
        idle();
        check("branch_flush_cnt", 32'(flush_cnt), 32'd1);
        check("branch_stall_cnt", 32'(stall_cnt), 32'd0);

        // Mul/div released by md_done 4 cycles after start; branch/load-use ignored while waiting
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("md_start", P_MDSTART);
        idle();
        step("md_wait1", P_MDWAIT);
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        step("md_wait2_ignore", P_MDWAIT);
        idle();
        step("md_wait3", P_MDWAIT);
        md_done = 1'b1;
        step("md_done", P_MDDONE);
        idle();
        step("md_back_run", P_NORMAL);
        check("md_stall_cnt", 32'(stall_cnt), 32'd4);
        check("md_flush_cnt", 32'(flush_cnt), 32'd0);

        // Timeout on the 8th wait cycle
        do_reset();
        id_ex_is_muldiv = 1'b1;
        step("to_start", P_MDSTART);
        idle();
        for (int i = 0; i < MD_TIMEOUT - 1; i++) begin
            step("to_wait", P_MDWAIT);
        end
        step("to_abort", P_MDABORT);
        check("to_err_set", 32'(md_timeout_err), 32'd1);
        check("to_stall_cnt", 32'(stall_cnt), 32'd8);
        for (int i = 0; i < 3; i++) begin
            step("to_run_after", P_NORMAL);
        end
        check("to_err_sticky", 32'(md_timeout_err), 32'd1);

        // md_done wins over timeout in the same cycle
        do_reset();
        check("err_cleared_by_rst", 32'(md_timeout_err), 32'd0);
        id_ex_is_muldiv = 1'b1;
        step("prio_start", P_MDSTART);
        idle();
        for (int i = 0; i < MD_TIMEOUT - 1; i++) begin
            step("prio_wait", P_MDWAIT);
        end
        md_done = 1'b1;
        step("prio_done", P_MDDONE);
        idle();
        check("prio_no_err", 32'(md_timeout_err), 32'd0);

        // Reset during MD_WAIT on the would-be timeout cycle
        do_reset();
        id_ex_is_muldiv = 1'b1;
        step("rw_start", P_MDSTART);
        idle();
        for (int i = 0; i < MD_TIMEOUT - 1; i++) begin
            step("rw_wait", P_MDWAIT);
        end
        rst = 1'b1;
        #1;
        check("rw_no_abort", 32'(md_abort), 32'd0);
        check("rw_busy", 32'(md_busy), 32'd1);
        tick();
        id_ex_is_muldiv = 1'b1;
        #1;
        check("rst_no_start", 32'(md_start), 32'd0);
        tick();
        rst = 1'b0;
        idle();
        step("rw_run", P_NORMAL);
        check("rw_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rw_err", 32'(md_timeout_err), 32'd0);

        // Counter saturation at all-ones
        do_reset();
        set_in(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step("sat_loaduse", P_LOADUSE);
        end
        check("stall_saturate", 32'(stall_cnt), 32'd15);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) begin
            step("sat_branch", P_BRANCH);
        end
        check("flush_saturate", 32'(flush_cnt), 32'd15);
        check("stall_held", 32'(stall_cnt), 32'd15);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
